// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap sequencer:
// CSR addresses, bit positions, cause codes and FSM states.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIP_MTIP     = 7;
    localparam int MIP_MEIP     = 11;

    localparam logic [31:0] MIE_WMASK = 32'h0000_0880;

    localparam logic [3:0] CAUSE_MEI = 4'd11;
    localparam logic [3:0] CAUSE_MTI = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TRAP,
        ST_RET,
        ST_DRAIN
    } trap_state_e;

endpackage

// File: rtl/trap_csr_regs.sv
// Machine-mode CSR storage, read mux and write masking.
// Trap entry and mret updates win over a same-edge CSR write.
module trap_csr_regs
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    input  logic        ext_irq_i,
    input  logic        timer_irq_i,
    input  logic        trap_i,
    input  logic [31:0] trap_pc_i,
    input  logic        mret_i,
    output logic        pending_o,
    output logic [31:0] mtvec_o,
    output logic [31:0] mepc_o
);

    logic        mstat_mie_q, mstat_mie_d;
    logic        mpie_q, mpie_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mip;
    logic [31:0] irq;
    logic [3:0]  code;

    always_comb begin
        mip = '0;
        mip[MIP_MEIP] = ext_irq_i;
        mip[MIP_MTIP] = timer_irq_i;
    end

    assign irq       = mie_q & mip;
    assign pending_o = mstat_mie_q & (|irq);
    assign code      = irq[MIP_MEIP] ? CAUSE_MEI : CAUSE_MTI;
    assign mtvec_o   = mtvec_q;
    assign mepc_o    = mepc_q;

    always_comb begin
        mstat_mie_d = mstat_mie_q;
        mpie_d      = mpie_q;
        mie_d       = mie_q;
        mtvec_d     = mtvec_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        if (we_i) begin
            case (addr_i)
                CSR_MSTATUS: begin
                    mstat_mie_d = wdata_i[MSTATUS_MIE];
                    mpie_d      = wdata_i[MSTATUS_MPIE];
                end
                CSR_MIE:    mie_d    = wdata_i & MIE_WMASK;
                CSR_MTVEC:  mtvec_d  = wdata_i & ~32'h3;
                CSR_MEPC:   mepc_d   = wdata_i & ~32'h3;
                CSR_MCAUSE: mcause_d = wdata_i;
                default: ;
            endcase
        end
        if (trap_i) begin
            mepc_d      = trap_pc_i & ~32'h3;
            mcause_d    = {1'b1, 27'b0, code};
            mpie_d      = mstat_mie_q;
            mstat_mie_d = 1'b0;
        end else if (mret_i) begin
            mstat_mie_d = mpie_q;
            mpie_d      = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mstat_mie_q <= 1'b0;
            mpie_q      <= 1'b0;
            mie_q       <= '0;
            mtvec_q     <= MTVEC_RESET & ~32'h3;
            mepc_q      <= '0;
            mcause_q    <= '0;
        end else begin
            mstat_mie_q <= mstat_mie_d;
            mpie_q      <= mpie_d;
            mie_q       <= mie_d;
            mtvec_q     <= mtvec_d;
            mepc_q      <= mepc_d;
            mcause_q    <= mcause_d;
        end
    end

    always_comb begin
        rdata_o = '0;
        case (addr_i)
            CSR_MSTATUS: begin
                rdata_o[12:11]        = 2'b11;
                rdata_o[MSTATUS_MPIE] = mpie_q;
                rdata_o[MSTATUS_MIE]  = mstat_mie_q;
            end
            CSR_MIE:    rdata_o = mie_q;
            CSR_MTVEC:  rdata_o = mtvec_q;
            CSR_MEPC:   rdata_o = mepc_q;
            CSR_MCAUSE: rdata_o = mcause_q;
            CSR_MIP:    rdata_o = mip;
            default:    rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/trap_controller.sv
// Machine-mode interrupt/trap sequencer: drives the E-stage flush
// and the fetch redirect for trap entry and mret.
module trap_controller
    import csr_pkg::*;
#(
    parameter logic [31:0] MTVEC_RESET  = 32'h0000_0100,
    parameter int unsigned DRAIN_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ext_irq,
    input  logic        timer_irq,
    input  logic [31:0] PCD,
    input  logic        ValidD,
    input  logic        PCSrcE,
    input  logic        returnE,
    input  logic        csr_we,
    input  logic [11:0] csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic        Int_flush,
    output logic        TrapRedirect,
    output logic [31:0] TrapPC
);

    localparam logic [2:0] CNT_LAST = 3'(DRAIN_CYCLES - 1);

    trap_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        pending;
    logic        take;
    logic        ret;
    logic        we;
    logic [31:0] mtvec;
    logic [31:0] mepc;

    assign we   = csr_we & (state_q != ST_DRAIN);
    assign ret  = (state_q == ST_IDLE) & returnE;
    assign take = (state_q == ST_IDLE) & pending & ValidD
                & ~PCSrcE & ~returnE & ~csr_we;

    trap_csr_regs #(
        .MTVEC_RESET(MTVEC_RESET)
    ) u_csr (
        .clk_i      (clk),
        .rst_i      (rst),
        .we_i       (we),
        .addr_i     (csr_addr),
        .wdata_i    (csr_wdata),
        .rdata_o    (csr_rdata),
        .ext_irq_i  (ext_irq),
        .timer_irq_i(timer_irq),
        .trap_i     (take),
        .trap_pc_i  (PCD),
        .mret_i     (ret),
        .pending_o  (pending),
        .mtvec_o    (mtvec),
        .mepc_o     (mepc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        Int_flush    = 1'b0;
        TrapRedirect = 1'b0;
        TrapPC       = '0;
        case (state_q)
            ST_IDLE: begin
                if (ret) state_d = ST_RET;
                else if (take) state_d = ST_TRAP;
            end
            ST_TRAP: begin
                Int_flush    = 1'b1;
                TrapRedirect = 1'b1;
                TrapPC       = mtvec;
                cnt_d        = '0;
                state_d      = ST_DRAIN;
            end
            ST_RET: begin
                Int_flush    = 1'b1;
                TrapRedirect = 1'b1;
                TrapPC       = mepc;
                cnt_d        = '0;
                state_d      = ST_DRAIN;
            end
            ST_DRAIN: begin
                Int_flush = 1'b1;
                cnt_d     = cnt_q + 3'd1;
                if (cnt_q == CNT_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_trap_controller.sv
// Scoreboard bench for trap_controller: expected redirects are queued
// when stimulus is driven and matched when TrapRedirect is observed.
module tb_trap_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        ext_irq, timer_irq;
    logic [31:0] PCD;
    logic        ValidD, PCSrcE, returnE, csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        Int_flush, TrapRedirect;
    logic [31:0] TrapPC;

    typedef struct {
        logic [31:0] pc;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   flush_run = 0;

    trap_controller dut (
        .clk         (clk),
        .rst         (rst),
        .ext_irq     (ext_irq),
        .timer_irq   (timer_irq),
        .PCD         (PCD),
        .ValidD      (ValidD),
        .PCSrcE      (PCSrcE),
        .returnE     (returnE),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .Int_flush   (Int_flush),
        .TrapRedirect(TrapRedirect),
        .TrapPC      (TrapPC)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst !== 1'b1 && TrapRedirect === 1'b1) begin
            if (sb.size() == 0) begin
                check("redir_unexp", 32'(TrapRedirect), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("redir_pc", TrapPC, e.pc);
                check("redir_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            flush_run = 0;
        end else if (Int_flush === 1'b1) begin
            flush_run++;
        end else if (flush_run != 0) begin
            check("flush_len", 32'(flush_run), 32'd3);
            flush_run = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_redirect(logic [31:0] pc);
        exp_t e;
        e.pc  = pc;
        e.cyc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic csr_write(logic [11:0] a, logic [31:0] d);
        csr_we    = 1'b1;
        csr_addr  = a;
        csr_wdata = d;
        tick();
        csr_we    = 1'b0;
    endtask

    task automatic rd(string tag, logic [11:0] a, logic [31:0] exp);
        csr_addr = a;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    task automatic quiet();
        ext_irq   = 1'b0;
        timer_irq = 1'b0;
        ValidD    = 1'b0;
        PCSrcE    = 1'b0;
        returnE   = 1'b0;
        csr_we    = 1'b0;
    endtask

    task automatic do_mret(logic [31:0] pc);
        returnE = 1'b1;
        expect_redirect(pc);
        tick();
        returnE = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        rst = 1'b1;
        quiet();
        PCD       = '0;
        csr_addr  = '0;
        csr_wdata = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_flush", 32'(Int_flush), 32'd0);
        check("rst_redir", 32'(TrapRedirect), 32'd0);
        check("rst_trappc", TrapPC, 32'd0);
        rd("rst_mtvec", 12'h305, 32'h0000_0100);
        rd("rst_mstatus", 12'h300, 32'h0000_1800);
        rd("rst_mepc", 12'h341, 32'h0);
        rd("rst_mie", 12'h304, 32'h0);

        // External interrupt trap; CSR write during drain must be dropped
        csr_write(12'h304, 32'h800);
        csr_write(12'h300, 32'h8);
        ext_irq = 1'b1;
        ValidD  = 1'b1;
        PCD     = 32'h40;
        expect_redirect(32'h100);
        tick();
        quiet();
        tick();
        csr_write(12'h305, 32'h500);
        repeat (3) tick();
        rd("t2_mepc", 12'h341, 32'h40);
        rd("t2_mcause", 12'h342, 32'h8000_000B);
        rd("t2_mstatus", 12'h300, 32'h0000_1880);
        rd("t2_mtvec_drain", 12'h305, 32'h100);

        do_mret(32'h40);
        rd("t4_mstatus", 12'h300, 32'h0000_1888);

        // Both sources, then timer only, then globally masked
        csr_write(12'h304, 32'h880);
        ext_irq   = 1'b1;
        timer_irq = 1'b1;
        ValidD    = 1'b1;
        PCD       = 32'h80;
        expect_redirect(32'h100);
        tick();
        quiet();
        repeat (4) tick();
        rd("t3_both_cause", 12'h342, 32'h8000_000B);
        do_mret(32'h80);
        timer_irq = 1'b1;
        ValidD    = 1'b1;
        PCD       = 32'hC4;
        expect_redirect(32'h100);
        tick();
        quiet();
        repeat (4) tick();
        rd("t3_tmr_cause", 12'h342, 32'h8000_0007);
        rd("t3_tmr_mepc", 12'h341, 32'hC4);
        do_mret(32'hC4);
        csr_write(12'h300, 32'h0);
        timer_irq = 1'b1;
        ValidD    = 1'b1;
        PCD       = 32'h99C;
        repeat (3) tick();
        rd("t3_mip", 12'h344, 32'h80);
        rd("t3_masked_mepc", 12'h341, 32'hC4);
        quiet();

        // Deferral by PCSrcE, !ValidD and csr_we
        csr_write(12'h300, 32'h8);
        ext_irq = 1'b1;
        PCSrcE  = 1'b1;
        ValidD  = 1'b1;
        PCD     = 32'h1C0;
        repeat (2) tick();
        PCSrcE = 1'b0;
        ValidD = 1'b0;
        repeat (2) tick();
        ValidD    = 1'b1;
        csr_we    = 1'b1;
        csr_addr  = 12'h7C0;
        csr_wdata = 32'hFFFF_FFFF;
        repeat (2) tick();
        csr_we = 1'b0;
        expect_redirect(32'h100);
        tick();
        quiet();
        repeat (4) tick();
        rd("t5_mepc", 12'h341, 32'h1C0);
        rd("t5_unmapped", 12'h7C0, 32'h0);
        rd("t5_mstatus", 12'h300, 32'h0000_1880);

        // returnE and a take-able interrupt in the same cycle
        csr_write(12'h300, 32'h8);
        ext_irq = 1'b1;
        ValidD  = 1'b1;
        PCD     = 32'h2A0;
        returnE = 1'b1;
        expect_redirect(32'h1C0);
        tick();
        quiet();
        repeat (4) tick();
        rd("t5_ret_mepc", 12'h341, 32'h1C0);
        rd("t5_ret_mstatus", 12'h300, 32'h0000_1880);

        // Write masking, then reset in the middle of a drain
        csr_write(12'h305, 32'h307);
        csr_write(12'h341, 32'h123);
        csr_write(12'h342, 32'hDEAD);
        csr_write(12'h304, 32'hFFFF_FFFF);
        csr_write(12'h300, 32'h8);
        rd("t6_mtvec_wr", 12'h305, 32'h304);
        rd("t6_mepc_wr", 12'h341, 32'h120);
        rd("t6_mcause_wr", 12'h342, 32'hDEAD);
        rd("t6_mie_wr", 12'h304, 32'h880);
        ext_irq = 1'b1;
        ValidD  = 1'b1;
        PCD     = 32'h3C0;
        expect_redirect(32'h304);
        tick();
        quiet();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_flush", 32'(Int_flush), 32'd0);
        check("t6_redir", 32'(TrapRedirect), 32'd0);
        check("t6_trappc", TrapPC, 32'd0);
        rd("t6_mtvec", 12'h305, 32'h100);
        rd("t6_mstatus", 12'h300, 32'h0000_1800);
        rd("t6_mepc", 12'h341, 32'h0);
        rd("t6_mcause", 12'h342, 32'h0);
        rd("t6_mie", 12'h304, 32'h0);
        repeat (2) tick();
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
